rom_loader: RTL and testbench
=============================

# rom_loader

Boot-image loader sitting directly upstream of the 4096 x 32 dual-port program memory. It consumes a byte stream from the host link (UART/debug bridge) over a valid/ready handshake and parses a framed image: length header, little-endian 32-bit payload words, trailing checksum. It drives the memory's write port 1 (we/addr/din), one word per write pulse. It reports busy/done/error to the boot controller, which holds the CPU in reset until done.

## Interface
Parameters:
- ADDR_W, 12, memory word-address width (depth 2**ADDR_W = 4096)
- DATA_W, 32, memory word width (fixed 4 bytes; other values unsupported)

Ports:
- clk  in  1  single clock; memory port 1 is clocked from the same clock
- rst  in  1  reset; **synchronous, active-high**
- start  in  1  one-cycle pulse; arms a new load from IDLE, DONE or ERR
- s_valid  in  1  byte stream valid
- s_data  in  8  byte stream data
- s_ready  out  1  loader accepts a byte this cycle when s_valid && s_ready
- mem_we  out  1  write strobe to memory port 1
- mem_addr  out  ADDR_W  word address
- mem_din  out  DATA_W  write data
- busy  out  1  load in progress
- done  out  1  image loaded and checksum good; held until next start
- error  out  1  bad length or checksum; held until next start
- words_written  out  ADDR_W+1  count of words written in current/last load

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start: go to LEN_LO. On entry, clear done, error, words_written, byte counter, sum and mem_addr. start in any other state is ignored.
- LEN_LO/LEN_HI: accept 16-bit length L, low byte first. After LEN_HI:
  - L == 0 or L > 4096: go to ERR with no writes.
  - Otherwise go to DATA.
- DATA: accept 4*L bytes, little-endian per word. Byte 0 goes to bits [7:0], byte 3 to bits [31:24].
  - On the cycle the 4th byte is accepted, the assembled word is registered to mem_din and mem_addr receives the word index.
  - mem_we is high for exactly the next cycle. words_written increments in that same cycle.
  - After the L-th word, go to CSUM.
- CSUM: accept one byte C. Let S = sum of all 4*L payload bytes mod 256; length bytes are excluded.
  - (S + C) mod 256 == 0: go to DONE.
  - Otherwise go to ERR. Words already written stay in memory; there is no rollback.
- s_ready = 1 only in LEN_LO, LEN_HI, DATA and CSUM; 0 elsewhere.
- busy = 1 in LEN_LO..CSUM. done = 1 only in DONE. error = 1 only in ERR.
- mem_addr wraps nowhere: L ≤ 4096 guarantees the last write is at 0xFFF.

## Timing
- Reset values: s_ready 0, mem_we 0, mem_addr 0, mem_din 0, busy 0, done 0, error 0, words_written 0, state IDLE.
- One byte per cycle maximum. s_ready does not depend combinationally on s_valid.
- Write latency: 4th byte accepted in cycle n → mem_we = 1 in cycle n+1 only.
- Back-to-back words: the next word's 4th byte is at the earliest n+4, so write pulses never overlap.
- Final word: its write pulse occurs in the cycle after the last DATA byte, which is also the first CSUM cycle. A checksum byte accepted in that same cycle is legal.
- done/error rise the cycle after the checksum byte (or LEN_HI byte) is accepted.
- Gaps in s_valid stall parsing indefinitely; there is no timeout.
- rst mid-load: next cycle state IDLE, all outputs at reset values. A pending mem_we is dropped.
- start and rst in the same cycle: rst wins.

## Test plan
- Good image: start; stream 02 00, 78 56 34 12, EF BE AD DE, B4 → two writes: addr 0 = 0x12345678, addr 1 = 0xDEADBEEF. Then done = 1, error = 0, words_written = 2.
- Bad checksum: same stream with final byte B5 → both writes occur, then error = 1, done = 0.
- Length errors: header 00 00 → error the cycle after LEN_HI, no mem_we, s_ready = 0. Header 01 10 (4097) → same result.
- Full image: L = 4096 (00 10), random payload, s_valid toggled randomly → 4096 single-cycle writes at addr 0..0xFFF with correct data, mem_we never high two cycles running, done = 1, words_written = 4096.
- Reset mid-DATA: after 6 payload bytes assert rst for 1 cycle → all outputs zero and s_ready = 0. start plus the good image then reloads correctly.
- start while busy is ignored (load continues unchanged). start in DONE clears done the next cycle and begins a fresh load.

Source files
------------

// File: rtl/rom_loader.sv
// Boot-image loader: parses a length/payload/checksum byte stream and writes
// little-endian 32-bit words into port 1 of the program memory.
module rom_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [16:0]   DEPTH = 17'(1 << ADDR_W);
  localparam logic [ADDR_W:0] ONE = 1;

  state_t            state, state_next;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   len;
  logic [1:0]        byte_cnt;
  logic [7:0]        sum;
  logic [23:0]       word_buf;
  logic              accept;
  logic [15:0]       len_full;
  logic              word_done;
  logic              last_word;
  logic              arm;

  assign accept    = s_valid && s_ready;
  assign len_full  = {s_data, len_lo};
  assign word_done = accept && (state == DATA) && (byte_cnt == 2'd3);
  assign last_word = ((words_written + ONE) == len);
  assign arm       = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        done  = (state == DONE);
        error = (state == ERR);
        if (start) state_next = LEN_LO;
      end
      LEN_LO: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (accept) state_next = LEN_HI;
      end
      LEN_HI: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (accept) begin
          if ((len_full == 16'd0) || ({1'b0, len_full} > DEPTH)) state_next = ERR;
          else                                                   state_next = DATA;
        end
      end
      DATA: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (word_done && last_word) state_next = CSUM;
      end
      CSUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (accept) state_next = ((sum + s_data) == 8'd0) ? DONE : ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload datapath; the write strobe is a one-cycle pulse after each 4th byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      words_written <= '0;
      len_lo        <= '0;
      len           <= '0;
      byte_cnt      <= '0;
      sum           <= '0;
      word_buf      <= '0;
    end else begin
      mem_we <= 1'b0;
      if (arm) begin
        words_written <= '0;
        byte_cnt      <= '0;
        sum           <= '0;
        mem_addr      <= '0;
      end
      if (accept) begin
        case (state)
          LEN_LO: len_lo <= s_data;
          LEN_HI: len    <= len_full[ADDR_W:0];
          DATA: begin
            sum      <= sum + s_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_din       <= {s_data, word_buf};
              mem_addr      <= words_written[ADDR_W-1:0];
              mem_we        <= 1'b1;
              words_written <= words_written + ONE;
            end else begin
              word_buf[{byte_cnt, 3'b000} +: 8] <= s_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized self-checking bench for rom_loader: a byte-position model predicts
// every output each cycle, and a memory scoreboard checks the written image.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, mem_we, busy, done, error;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic [12:0] words_written;

  always #5 clk = ~clk;

  rom_loader dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else begin
      fails++;
      if (fails <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: tracks the frame by byte position and the load outcome.
  bit          m_loading = 0;
  int          m_result  = 0;
  int          m_pos, m_len, m_sum, m_words;
  bit          m_we = 0;
  logic [11:0] m_addr = '0;
  logic [31:0] m_din  = '0;
  logic [7:0]  m_bytes [4];

  task automatic model_step();
    int b;
    bit we_next = 0;
    if (rst) begin
      m_loading = 0; m_result = 0; m_words = 0; m_addr = '0; m_din = '0;
    end else if (!m_loading && start) begin
      m_loading = 1; m_result = 0; m_words = 0; m_pos = 0; m_sum = 0; m_addr = '0;
    end else if (m_loading && s_valid) begin
      if (m_pos == 0) m_len = int'(s_data);
      else if (m_pos == 1) begin
        m_len = m_len + 256 * int'(s_data);
        if (m_len == 0 || m_len > 4096) begin m_loading = 0; m_result = 2; end
      end else if (m_pos < 2 + 4 * m_len) begin
        b = m_pos - 2;
        m_bytes[b % 4] = s_data;
        m_sum = m_sum + int'(s_data);
        if (b % 4 == 3) begin
          we_next = 1;
          m_din   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_addr  = 12'(b / 4);
          m_words = b / 4 + 1;
        end
      end else begin
        m_result  = ((m_sum + int'(s_data)) % 256 == 0) ? 1 : 2;
        m_loading = 0;
      end
      m_pos++;
    end
    m_we = we_next;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  logic [31:0] dut_mem [0:4095];
  logic [31:0] exp_img [0:4095];
  int we_count = 0;

  initial forever begin
    @(posedge clk);
    if (mem_we) begin
      dut_mem[mem_addr] = mem_din;
      we_count++;
    end
  end

  bit cmp_en = 0;

  initial begin
    bit prev_we = 0;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checkOutput("s_ready", 32'(s_ready), 32'(m_loading));
        checkOutput("busy", 32'(busy), 32'(m_loading));
        checkOutput("done", 32'(done), 32'(m_result == 1));
        checkOutput("error", 32'(error), 32'(m_result == 2));
        checkOutput("mem_we", 32'(mem_we), 32'(m_we));
        checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
        checkOutput("mem_din", mem_din, m_din);
        checkOutput("words_written", 32'(words_written), 32'(m_words));
        if (mem_we && prev_we) checkOutput("we_back_to_back", 32'd1, 32'd0);
        prev_we = mem_we;
      end
    end
  end

  logic [7:0] tx [$];

  // Drives one byte, inserting random idle gaps; the byte is taken when the model is loading.
  task automatic applyStimulus(input logic [7:0] b, input int gap_pct);
    bit acc;
    int tries = 0;
    forever begin
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        @(posedge clk); #1;
      end else begin
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
        acc = m_loading;
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (acc) break;
        tries++;
        if (tries > 50) begin
          checkOutput("byte_accept_timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
  endtask

  task automatic send_queue(input int gap_pct);
    foreach (tx[i]) applyStimulus(tx[i], gap_pct);
    tx.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_good_image(input bit bad_csum);
    tx.push_back(8'h02); tx.push_back(8'h00);
    tx.push_back(8'h78); tx.push_back(8'h56); tx.push_back(8'h34); tx.push_back(8'h12);
    tx.push_back(8'hEF); tx.push_back(8'hBE); tx.push_back(8'hAD); tx.push_back(8'hDE);
    tx.push_back(bad_csum ? 8'hB5 : 8'hB4);
  endtask

  // Random frame of n words; expected image goes into exp_img.
  task automatic push_random_frame(input int n, input bit good);
    int s = 0;
    logic [7:0] bv;
    tx.push_back(8'(n)); tx.push_back(8'(n >> 8));
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        bv = 8'($urandom);
        exp_img[w][8*k +: 8] = bv;
        s += int'(bv);
        tx.push_back(bv);
      end
    end
    tx.push_back(good ? 8'((256 - s % 256) % 256) : 8'((257 - s % 256) % 256));
  endtask

  task automatic check_good_image(input string tag);
    checkOutput({tag, "_addr0"}, dut_mem[0], 32'h12345678);
    checkOutput({tag, "_addr1"}, dut_mem[1], 32'hDEADBEEF);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_words"}, 32'(words_written), 32'd2);
  endtask

  initial begin
    int w0;
    idle_cycles(2);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_words", 32'(words_written), 32'd0);
    @(posedge clk); #1;

    // Good image, then bad checksum.
    pulse_start(); push_good_image(0); send_queue(0); idle_cycles(2);
    check_good_image("good");
    dut_mem[0] = '0; dut_mem[1] = '0;
    w0 = we_count;
    pulse_start(); push_good_image(1); send_queue(30); idle_cycles(2);
    checkOutput("badcsum_writes", 32'(we_count - w0), 32'd2);
    checkOutput("badcsum_addr1", dut_mem[1], 32'hDEADBEEF);
    checkOutput("badcsum_error", 32'(error), 32'd1);
    checkOutput("badcsum_done", 32'(done), 32'd0);

    // Length errors.
    w0 = we_count;
    pulse_start(); tx.push_back(8'h00); tx.push_back(8'h00); send_queue(0);
    @(negedge clk);
    checkOutput("len0_error", 32'(error), 32'd1);
    checkOutput("len0_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    pulse_start(); tx.push_back(8'h01); tx.push_back(8'h10); send_queue(0);
    @(negedge clk);
    checkOutput("len4097_error", 32'(error), 32'd1);
    checkOutput("len_err_writes", 32'(we_count - w0), 32'd0);
    @(posedge clk); #1;

    // Start while busy is ignored.
    pulse_start(); push_good_image(0);
    for (int i = 0; i < 6; i++) applyStimulus(tx[i], 0);
    pulse_start();
    for (int i = 6; i < 11; i++) applyStimulus(tx[i], 0);
    tx.delete(); idle_cycles(2);
    check_good_image("busy_start");

    // Start in DONE clears done the next cycle.
    pulse_start();
    @(negedge clk);
    checkOutput("restart_done_clr", 32'(done), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;

    // Reset mid-DATA after 6 payload bytes.
    push_good_image(0);
    for (int i = 0; i < 8; i++) applyStimulus(tx[i], 0);
    tx.delete();
    rst = 1'b1; idle_cycles(1); rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_mem_din", mem_din, 32'd0);
    checkOutput("midrst_words", 32'(words_written), 32'd0);
    @(posedge clk); #1;
    dut_mem[0] = '0; dut_mem[1] = '0;
    pulse_start(); push_good_image(0); send_queue(20); idle_cycles(2);
    check_good_image("reload");

    // start and rst together: reset wins.
    rst = 1'b1; start = 1'b1; idle_cycles(1); rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput("rst_start_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Short random frames, some with bad checksums.
    for (int f = 0; f < 6; f++) begin
      int n = int'($urandom_range(1, 6));
      pulse_start(); push_random_frame(n, (f % 3) != 2); send_queue(35); idle_cycles(2);
      for (int i = 0; i < n; i++) checkOutput("rand_word", dut_mem[i], exp_img[i]);
    end

    // Full 4096-word image with random valid gaps.
    w0 = we_count;
    pulse_start(); push_random_frame(4096, 1); send_queue(40); idle_cycles(2);
    checkOutput("full_writes", 32'(we_count - w0), 32'd4096);
    checkOutput("full_done", 32'(done), 32'd1);
    checkOutput("full_words", 32'(words_written), 32'd4096);
    for (int i = 0; i < 4096; i++) checkOutput("full_word", dut_mem[i], exp_img[i]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
